// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: one op at a time, req/gnt/rvalid handshake to a
// 64-bit data SRAM, byte-lane steering, load extension and error reporting.
module mem_stage_lsu #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic              ex_is_store,
  input  logic [2:0]        ex_func3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [63:0]       ex_wdata,
  input  logic [4:0]        ex_rd,
  output logic              ex_ready,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [7:0]        dm_be,
  output logic [63:0]       dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [63:0]       dm_rdata,
  output logic              wb_valid,
  output logic              wb_is_load,
  output logic [4:0]        wb_rd,
  output logic [63:0]       wb_data,
  output logic              err,
  output logic [1:0]        err_cause
);
  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        func3_q, func3_d, off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic              load_q, load_d;
  logic              dm_req_d, dm_we_d;
  logic [ADDR_W-1:0] dm_addr_d;
  logic [7:0]        dm_be_d;
  logic [63:0]       dm_wdata_d;
  logic              wb_valid_d, wb_is_load_d, err_d;
  logic [4:0]        wb_rd_d;
  logic [63:0]       wb_data_d;
  logic [1:0]        err_cause_d;
  logic              accept, illegal, misaligned, expire;
  logic [7:0]        size_mask;
  logic [63:0]       lane_data, load_ext;

  assign ex_ready = (state_q == IDLE);
  assign stall    = (state_q != IDLE);
  assign accept   = ex_valid & ex_ready & (ex_is_load | ex_is_store);

  // Classify the incoming op; illegal outranks misaligned
  always_comb begin
    illegal = (ex_is_load & ex_is_store) | (ex_is_load & (ex_func3 == 3'b111)) |
              (ex_is_store & ex_func3[2]);
    case (ex_func3[1:0])
      2'd0:    begin size_mask = 8'h01; misaligned = 1'b0;            end
      2'd1:    begin size_mask = 8'h03; misaligned = ex_addr[0];      end
      2'd2:    begin size_mask = 8'h0F; misaligned = |ex_addr[1:0];   end
      default: begin size_mask = 8'hFF; misaligned = |ex_addr[2:0];   end
    endcase
  end

  // Select the addressed lane of the read doubleword and extend it
  always_comb begin
    lane_data = dm_rdata >> {off_q, 3'b000};
    case (func3_q)
      3'b000:  load_ext = {{56{lane_data[7]}},  lane_data[7:0]};
      3'b001:  load_ext = {{48{lane_data[15]}}, lane_data[15:0]};
      3'b010:  load_ext = {{32{lane_data[31]}}, lane_data[31:0]};
      3'b100:  load_ext = {56'd0, lane_data[7:0]};
      3'b101:  load_ext = {48'd0, lane_data[15:0]};
      3'b110:  load_ext = {32'd0, lane_data[31:0]};
      default: load_ext = lane_data;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    func3_d      = func3_q;
    off_d        = off_q;
    rd_d         = rd_q;
    load_d       = load_q;
    dm_req_d     = dm_req;
    dm_we_d      = dm_we;
    dm_addr_d    = dm_addr;
    dm_be_d      = dm_be;
    dm_wdata_d   = dm_wdata;
    wb_valid_d   = 1'b0;
    wb_is_load_d = wb_is_load;
    wb_rd_d      = wb_rd;
    wb_data_d    = wb_data;
    err_d        = err;
    err_cause_d  = err_cause;
    expire       = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        func3_d = ex_func3;
        off_d   = ex_addr[2:0];
        rd_d    = ex_rd;
        load_d  = ex_is_load & ~ex_is_store;
        if (illegal | misaligned) begin
          state_d      = DONE;
          wb_valid_d   = 1'b1;
          wb_is_load_d = ex_is_load & ~ex_is_store;
          wb_rd_d      = 5'd0;
          wb_data_d    = 64'd0;
          err_d        = 1'b1;
          err_cause_d  = illegal ? 2'd2 : 2'd1;
        end else begin
          state_d    = REQ;
          cnt_d      = '0;
          dm_req_d   = 1'b1;
          dm_we_d    = ex_is_store;
          dm_addr_d  = {ex_addr[ADDR_W-1:3], 3'b000};
          dm_be_d    = ex_is_store ? (size_mask << ex_addr[2:0]) : 8'h00;
          dm_wdata_d = ex_wdata << {ex_addr[2:0], 3'b000};
        end
      end
      REQ: if (dm_gnt) begin
        dm_req_d = 1'b0;
        cnt_d    = cnt_q + CNT_W'(1);
        if (load_q) begin
          state_d = RESP;
        end else begin
          state_d      = DONE;
          wb_valid_d   = 1'b1;
          wb_is_load_d = 1'b0;
          wb_rd_d      = 5'd0;
          wb_data_d    = 64'd0;
          err_d        = 1'b0;
          err_cause_d  = 2'd0;
        end
      end else if (cnt_q >= CNT_LAST) begin
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      RESP: if (dm_rvalid) begin
        state_d      = DONE;
        wb_valid_d   = 1'b1;
        wb_is_load_d = 1'b1;
        wb_rd_d      = rd_q;
        wb_data_d    = load_ext;
        err_d        = 1'b0;
        err_cause_d  = 2'd0;
      end else if (cnt_q >= CNT_LAST) begin
        expire = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // Abort a stuck access; later rvalid is ignored since RESP has been left
    if (expire) begin
      state_d      = DONE;
      dm_req_d     = 1'b0;
      wb_valid_d   = 1'b1;
      wb_is_load_d = load_q;
      wb_rd_d      = 5'd0;
      wb_data_d    = 64'd0;
      err_d        = 1'b1;
      err_cause_d  = 2'd3;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      func3_q    <= 3'd0;
      off_q      <= 3'd0;
      rd_q       <= 5'd0;
      load_q     <= 1'b0;
      dm_req     <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      dm_be      <= 8'h00;
      dm_wdata   <= 64'd0;
      wb_valid   <= 1'b0;
      wb_is_load <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 64'd0;
      err        <= 1'b0;
      err_cause  <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      func3_q    <= func3_d;
      off_q      <= off_d;
      rd_q       <= rd_d;
      load_q     <= load_d;
      dm_req     <= dm_req_d;
      dm_we      <= dm_we_d;
      dm_addr    <= dm_addr_d;
      dm_be      <= dm_be_d;
      dm_wdata   <= dm_wdata_d;
      wb_valid   <= wb_valid_d;
      wb_is_load <= wb_is_load_d;
      wb_rd      <= wb_rd_d;
      wb_data    <= wb_data_d;
      err        <= err_d;
      err_cause  <= err_cause_d;
    end
  end
endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
Load/store unit for the MEM stage. It sits directly downstream of the EX/MEM pipeline register and upstream of MEM/WB. It accepts one memory op at a time, drives a req/gnt/rvalid handshake to the 64-bit data SRAM, and stalls the core while busy. It returns byte-laned, sign- or zero-extended load data plus rd toward WB, and flags misaligned, illegal and timed-out accesses.

Parameters:
ADDR_W, 32, byte-address width
TIMEOUT_CYC, 64, max cycles waiting in REQ or RESP before abort

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
ex_valid  in  1  EX/MEM holds a memory op
ex_is_load  in  1  op is a load
ex_is_store  in  1  op is a store
ex_func3  in  3  RV64 width/sign code
ex_addr  in  ADDR_W  effective byte address (EX result)
ex_wdata  in  64  store data, right-aligned
ex_rd  in  5  load destination register
ex_ready  out  1  LSU can accept (state IDLE)
stall  out  1  hold pipeline (state != IDLE)
dm_req  out  1  memory request
dm_we  out  1  1=write
dm_addr  out  ADDR_W  doubleword-aligned address, bits[2:0]=0
dm_be  out  8  byte enables
dm_wdata  out  64  lane-shifted store data
dm_gnt  in  1  request accepted
dm_rvalid  in  1  read data valid
dm_rdata  in  64  read data
wb_valid  out  1  one-cycle completion pulse
wb_is_load  out  1  completed op was a load
wb_rd  out  5  destination (0 for stores/errors)
wb_data  out  64  extended load data (0 for stores/errors)
err  out  1  completion carries error (valid with wb_valid)
err_cause  out  2  1=misaligned, 2=illegal func3/op, 3=timeout

Behaviour:
- Reset (rst=0, async): state IDLE, timeout counter 0; dm_req, dm_we, dm_addr, dm_be, dm_wdata, wb_valid, wb_is_load, wb_rd, wb_data, err and err_cause all 0. ex_ready=1 and stall=0 follow from IDLE.
- Reset mid-operation aborts the access. dm_req drops immediately and no wb_valid is issued for the aborted op.
- Accept: ex_valid & ex_ready & (ex_is_load | ex_is_store) at a rising edge. The unit latches func3, addr[2:0], rd and type.
- ex_valid with neither type flag set is ignored.
- Legal func3 for loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Legal func3 for stores: 000–011. Any other code, or both type flags set, is illegal (cause 2).
- Misaligned (cause 1): half with addr[0]!=0; word with addr[1:0]!=0; double with addr[2:0]!=0. Illegal takes priority over misaligned.
- An error detected at accept issues no memory access. Next state is DONE with err=1.
- FSM states: IDLE, REQ, RESP, DONE.
  - IDLE -> REQ on a legal accept; IDLE -> DONE on an erroneous accept.
  - REQ: dm_req=1; dm_addr, dm_we, dm_be and dm_wdata are held stable until dm_gnt. On gnt: a store goes to DONE, a load goes to RESP.
  - RESP: dm_req=0. dm_rvalid is sampled only in RESP, i.e. no earlier than the cycle after gnt. On rvalid, capture and extend the data, then go to DONE.
  - DONE: wb_valid=1 for exactly one cycle, then IDLE. The next op can be accepted in the cycle after DONE.
- Timeout: the counter clears on entering REQ and increments each cycle in REQ or RESP. When it reaches TIMEOUT_CYC, go to DONE with err=1, cause 3, dm_req dropped. A late dm_rvalid arriving after that is ignored.
- Byte lanes: size mask is 0x01, 0x03, 0x0F or 0xFF. dm_be = mask << addr[2:0]. dm_wdata = ex_wdata << (8*addr[2:0]). dm_be=0 for loads.
- Load data: s = dm_rdata >> (8*addr[2:0]), truncated to size. LB/LH/LW sign-extend to 64; LBU/LHU/LWU zero-extend; LD passes through.
- wb_rd, wb_data, wb_is_load, err and err_cause update on entry to DONE and hold until the next DONE.
- Latency from the accept edge, gnt immediate: store wb_valid at +2 cycles; load with rvalid the cycle after gnt at +3 cycles.

Test Plan:
- SD addr 0x100, data 0x1122334455667788, gnt in first REQ cycle -> dm_addr=0x100, dm_be=0xFF, dm_we=1; wb_valid 2 cycles after accept, err=0.
- LB addr 0x103, rdata 0x00000000_80FF0000, rd=5 -> dm_be=0x00; byte 0x80 at lane 3; wb_data=0xFFFFFFFFFFFFFF80, wb_rd=5. Same data with LBU -> 0x80.
- SH addr 0x106, data 0xBEEF -> dm_be=0xC0, dm_wdata=0xBEEF000000000000. LW addr 0x102 -> no dm_req; wb_valid next cycle, err=1, cause=1.
- Load with gnt held low 3 cycles and rvalid 2 cycles after gnt -> request fields stable throughout; stall=1 until DONE; wb_valid exactly once.
- dm_gnt never asserted, TIMEOUT_CYC=64 -> wb_valid at cycle 65 after accept, err=1, cause=3; next op accepted normally. func3=111 load -> cause=2.
- rst pulsed low while in RESP -> dm_req/wb_valid 0 immediately; no completion for the aborted op; after release the first LD completes correctly.
